fifo_wr_arbiter: RTL

//  Shares the single write port of one FIFO between N_REQ requesters (per-requester valid/ack).

---
 rtl/fifo_arb_pkg.sv | 10 +
 rtl/rr_picker.sv | 33 +++
 rtl/fifo_wr_arbiter.sv | 109 ++++++++++
 3 files changed

// File: rtl/fifo_arb_pkg.sv
// Shared types and defaults for the FIFO write-port arbiter.
package fifo_arb_pkg;

    typedef enum logic {IDLE, BURST} arb_state_t;

    localparam int DW_DEF        = 8;
    localparam int N_REQ_DEF     = 4;
    localparam int BURST_MAX_DEF = 4;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first asserted req at or after start_i, wrapping.
module rr_picker
    import fifo_arb_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEF,
    localparam int IW   = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [IW-1:0]    start_i,
    output logic             found_o,
    output logic [IW-1:0]    idx_o,
    output logic [N_REQ-1:0] onehot_o
);

    // Scan from the farthest offset down so the nearest hit is the last one written.
    always_comb begin
        int j;
        j        = 0;
        found_o  = 1'b0;
        idx_o    = '0;
        onehot_o = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            j = (int'(start_i) + i) % N_REQ;
            if (req_i[j]) begin
                found_o     = 1'b1;
                idx_o       = IW'(j);
                onehot_o    = '0;
                onehot_o[j] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter sharing one FIFO write port between N_REQ requesters.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int N_REQ     = N_REQ_DEF,
    parameter int DW        = DW_DEF,
    parameter int BURST_MAX = BURST_MAX_DEF
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [N_REQ-1:0]    req,
    input  logic [N_REQ*DW-1:0] req_data,
    output logic [N_REQ-1:0]    req_ack,
    output logic [N_REQ-1:0]    gnt,
    input  logic                fifo_full,
    output logic                fifo_wr,
    output logic [DW-1:0]       fifo_data,
    output logic                busy
);

    localparam int IW = $clog2(N_REQ);
    localparam int CW = $clog2(BURST_MAX + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(BURST_MAX - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(N_REQ - 1);

    arb_state_t       state_q, state_d;
    logic [IW-1:0]    owner_q, owner_d, rr_ptr_q, rr_ptr_d;
    logic [IW-1:0]    owner_nxt, pick_start, pick_idx;
    logic [N_REQ-1:0] gnt_q, gnt_d, pick_oh;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             pick_found, in_burst, cap, release_w;

    assign in_burst   = (state_q == BURST);
    assign owner_nxt  = (owner_q == IDX_LAST) ? '0 : owner_q + IW'(1);
    // On release the search starts just past the owner, so handoff needs no bubble.
    assign pick_start = in_burst ? owner_nxt : rr_ptr_q;

    rr_picker #(.N_REQ(N_REQ)) u_pick (
        .req_i    (req),
        .start_i  (pick_start),
        .found_o  (pick_found),
        .idx_o    (pick_idx),
        .onehot_o (pick_oh)
    );

    assign fifo_wr   = in_burst & req[owner_q] & ~fifo_full & ~reset;
    assign req_ack   = N_REQ'(fifo_wr) << owner_q;
    assign fifo_data = req_data[owner_q*DW +: DW];
    assign gnt       = gnt_q;
    assign busy      = in_burst;
    assign cap       = fifo_wr & (cnt_q == CNT_LAST);
    assign release_w = in_burst & (~req[owner_q] | cap);

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        gnt_d    = gnt_q;
        cnt_d    = cnt_q;
        rr_ptr_d = rr_ptr_q;
        case (state_q)
            IDLE: begin
                if (pick_found) begin
                    state_d = BURST;
                    owner_d = pick_idx;
                    gnt_d   = pick_oh;
                    cnt_d   = '0;
                end
            end
            BURST: begin
                if (release_w) begin
                    rr_ptr_d = owner_nxt;
                    cnt_d    = '0;
                    if (pick_found) begin
                        owner_d = pick_idx;
                        gnt_d   = pick_oh;
                    end else begin
                        state_d = IDLE;
                        gnt_d   = '0;
                    end
                end else if (fifo_wr) begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            owner_q  <= '0;
            gnt_q    <= '0;
            cnt_q    <= '0;
            rr_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            gnt_q    <= gnt_d;
            cnt_q    <= cnt_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    a_gnt_onehot: assert property (@(posedge clk) disable iff (reset) $onehot0(gnt_q));
    a_ack_onehot: assert property (@(posedge clk) disable iff (reset) $onehot0(req_ack));
    a_ack_wr:     assert property (@(posedge clk) disable iff (reset) (|req_ack) |-> fifo_wr);
    a_wr_full:    assert property (@(posedge clk) disable iff (reset) fifo_wr |-> !fifo_full);

endmodule
